// File: rtl/inst_fetch_queue_pkg.sv
// Shared defaults for the instruction-fetch front end: bus widths, reset PC
// and sequential PC step.
package inst_fetch_queue_pkg;

  localparam int ADDR_LEN = 64;
  localparam int INST_LEN = 32;
  localparam int PC_STEP_DEFAULT = 4;
  localparam logic [ADDR_LEN-1:0] RESET_PC_DEFAULT = '0;

  // Pointer width for a wrapping ring of 'depth' entries (one extra lap bit).
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order slot ring for fetches: allocate on request, fill on response,
// pop on delivery, flush on redirect. Head entry is exposed combinationally.
module fetch_slot_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN,
  parameter int INST_W = INST_LEN,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc,
  input  logic [ADDR_W-1:0]           alloc_pc,
  input  logic                        fill,
  input  logic [INST_W-1:0]           fill_inst,
  input  logic                        pop,
  input  logic                        flush,
  output logic [ptr_w(DEPTH)-1:0]     occ,
  output logic [ptr_w(DEPTH)-1:0]     in_flight,
  output logic                        head_filled,
  output logic [ADDR_W-1:0]           head_pc,
  output logic [INST_W-1:0]           head_inst
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0]        alloc_ptr, fill_ptr, read_ptr;
  logic [ADDR_W-1:0]  pc_q   [DEPTH];
  logic [INST_W-1:0]  inst_q [DEPTH];
  logic [DEPTH-1:0]   filled;

  // NOTE: the slot payload is reset too, because the head pc/inst drive the
  // outputs directly and must read as zero while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      filled    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      filled    <= '0;
    end else begin
      if (alloc) begin
        pc_q[alloc_ptr[IW-1:0]]   <= alloc_pc;
        filled[alloc_ptr[IW-1:0]] <= 1'b0;
        alloc_ptr                 <= alloc_ptr + (IW+1)'(1);
      end
      if (fill) begin
        inst_q[fill_ptr[IW-1:0]] <= fill_inst;
        filled[fill_ptr[IW-1:0]] <= 1'b1;
        fill_ptr                 <= fill_ptr + (IW+1)'(1);
      end
      if (pop) begin
        filled[read_ptr[IW-1:0]] <= 1'b0;
        read_ptr                 <= read_ptr + (IW+1)'(1);
      end
    end
  end

  assign occ         = alloc_ptr - read_ptr;
  assign in_flight   = alloc_ptr - fill_ptr;
  assign head_filled = filled[read_ptr[IW-1:0]];
  assign head_pc     = pc_q[read_ptr[IW-1:0]];
  assign head_inst   = inst_q[read_ptr[IW-1:0]];

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupled fetch front end: issues in-order memory requests while credit
// remains, buffers responses, and discards stale responses after a redirect.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_LEN,
  parameter int                INST_W   = INST_LEN,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic              busy_o
);

  localparam int CW = ptr_w(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     disc_cnt, occ, in_flight;
  logic [CW:0]       used;
  logic              credit, req_fire, drop, fill, out_fire, head_filled;

  // Credit covers both live slots and stale requests still owed by memory.
  assign used     = {1'b0, occ} + {1'b0, disc_cnt};
  assign credit   = used < (CW+1)'(DEPTH);

  assign imem_req_valid_o = rst & credit & ~jmp;
  assign imem_req_addr_o  = fetch_pc;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;

  assign drop     = imem_rsp_valid_i & (disc_cnt != '0);
  assign fill     = imem_rsp_valid_i & ~drop;

  assign out_valid_o = head_filled & (occ != '0);
  assign out_fire    = out_valid_o & out_ready_i;
  assign busy_o      = (disc_cnt != '0);

  fetch_slot_queue #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_slots (
    .clk         (clk),
    .rst         (rst),
    .alloc       (req_fire),
    .alloc_pc    (fetch_pc),
    .fill        (fill),
    .fill_inst   (imem_rsp_data_i),
    .pop         (out_fire),
    .flush       (jmp),
    .occ         (occ),
    .in_flight   (in_flight),
    .head_filled (head_filled),
    .head_pc     (out_pc_o),
    .head_inst   (out_inst_o)
  );

  // On redirect every outstanding request becomes a discard, less the one
  // response (live or stale) that lands in this very cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      disc_cnt <= '0;
    end else if (jmp) begin
      fetch_pc <= {jmp_pc_i[ADDR_W-1:2], 2'b00};
      disc_cnt <= disc_cnt + in_flight - CW'(imem_rsp_valid_i);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      if (drop)     disc_cnt <= disc_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: variable-latency memory model plus
// an epoch-based reference of which fetches must reach decode, and in what order.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk, rst, jmp;
  logic [63:0] jmp_pc_i;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        out_valid_o, out_ready_i;
  logic [63:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic        busy_o;

  inst_fetch_queue #(
    .ADDR_W (64), .INST_W (32), .DEPTH (DEPTH), .RESET_PC (RESET_PC), .PC_STEP (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .jmp              (jmp),
    .jmp_pc_i         (jmp_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_pc_o         (out_pc_o),
    .out_inst_o       (out_inst_o),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];   // requests accepted by memory, oldest first
  logic [63:0] buf_q[$];   // pcs of current-stream instructions awaiting decode
  logic [63:0] m_pc;
  int          epoch, cyc, lat;
  bit          rsp_gap;
  int          n_checks, n_fails;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ {a[63:48], a[15:0]} ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    buf_q.delete();
    m_pc = RESET_PC;
  endtask

  // One clock cycle: drive at negedge, compare settled outputs, update model at posedge.
  task automatic step(input bit j, input logic [63:0] jpc, input bit rdy, input bit ordy);
    bit   rsp, exp_rv, ofire;
    int   stale;
    @(negedge clk);
    jmp              = j;
    jmp_pc_i         = jpc;
    imem_req_ready_i = rdy;
    out_ready_i      = ordy;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc) &&
          !(rsp_gap && $urandom_range(0, 3) == 0);
    imem_rsp_valid_i = rsp;
    imem_rsp_data_i  = rsp ? inst_of(mem_q[0].addr) : 32'h0;
    #1;
    stale = 0;
    foreach (mem_q[k]) if (mem_q[k].epoch != epoch) stale++;
    exp_rv = !j && (mem_q.size() + buf_q.size() < DEPTH);
    check("req_valid", 64'(imem_req_valid_o), 64'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr_o, m_pc);
    check("out_valid", 64'(out_valid_o), 64'(buf_q.size() > 0));
    if (buf_q.size() > 0) begin
      check("out_pc", out_pc_o, buf_q[0]);
      check("out_inst", 64'(out_inst_o), 64'(inst_of(buf_q[0])));
    end
    check("busy", 64'(busy_o), 64'(stale > 0));
    ofire = (buf_q.size() > 0) && ordy;
    @(posedge clk);
    if (ofire) void'(buf_q.pop_front());
    if (rsp) begin
      mreq_t h;
      assert (mem_q.size() > 0) else $fatal(1, "FAIL rsp_without_req");
      h = mem_q.pop_front();
      if (h.epoch == epoch) buf_q.push_back(h.addr);
    end
    if (exp_rv && rdy) begin
      mem_q.push_back('{addr: m_pc, epoch: epoch, due: cyc + lat});
      m_pc = m_pc + 64'd4;
    end
    if (j) begin
      epoch++;
      buf_q.delete();
      m_pc = {jpc[63:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(imem_req_valid_o), 64'h0);
    check({tag, "_out_valid"}, 64'(out_valid_o), 64'h0);
    check({tag, "_out_pc"}, out_pc_o, 64'h0);
    check({tag, "_out_inst"}, 64'(out_inst_o), 64'h0);
    check({tag, "_busy"}, 64'(busy_o), 64'h0);
  endtask

  initial begin
    n_checks = 0; n_fails = 0; cyc = 0; epoch = 0; lat = 1; rsp_gap = 0;
    rst = 1'b0; jmp = 1'b0; jmp_pc_i = '0; imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; out_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #2 rst = 1'b1;

    // 1: latency 1, always ready: back-to-back stream from RESET_PC
    repeat (10) step(0, '0, 1, 1);

    // 2: decode stalled: queue fills to DEPTH, then drains in order
    repeat (8) step(0, '0, 1, 0);
    repeat (10) step(0, '0, 1, 1);

    // 3: latency 3, redirect with requests outstanding; low bits ignored
    lat = 3;
    repeat (6) step(0, '0, 1, 1);
    step(1, 64'h1003, 1, 1);
    repeat (10) step(0, '0, 1, 1);

    // 4: redirect coinciding with a response and an output handshake
    lat = 1;
    repeat (5) step(0, '0, 1, 1);
    step(1, 64'h8, 1, 1);
    repeat (6) step(0, '0, 1, 1);

    // 5: back-to-back redirects, then PC wrap at the top of the address space
    lat = 2;
    repeat (4) step(0, '0, 1, 1);
    step(1, 64'h100, 1, 1);
    step(0, '0, 1, 1);
    step(1, 64'h200, 1, 1);
    repeat (8) step(0, '0, 1, 1);
    step(1, 64'hFFFF_FFFF_FFFF_FFF9, 1, 1);
    repeat (8) step(0, '0, 1, 1);

    // 6: async reset between edges while the stream is running
    lat = 2;
    repeat (5) step(0, '0, 1, 1);
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    jmp = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (8) step(0, '0, 1, 1);

    // Randomised traffic: ready/stall/redirect mix with varying latency and gaps
    rsp_gap = 1;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) lat = 1 + $urandom_range(0, 3);
      step($urandom_range(0, 19) == 0, {$urandom, $urandom},
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    rsp_gap = 0;
    repeat (12) step(0, '0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
